// File: rtl/micro_sequencer.sv
// Sequential front end of the control unit: instruction register, microstep
// counter, latched ALU flags, run/pause/single-step control and halt/fault status.
module micro_sequencer #(
    parameter int unsigned INSTRUCTION_WIDTH = 16,
    parameter int unsigned INSTRUCTION_STEPS = 32,
    parameter int unsigned RETIRED_WIDTH     = 32,
    localparam int unsigned STEP_WIDTH       = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [INSTRUCTION_WIDTH-1:0] i_bus,
    input  logic                         i_ii,
    input  logic                         i_el,
    input  logic                         i_adv,
    input  logic                         i_hlt,
    input  logic                         i_alu_zero,
    input  logic                         i_alu_carry,
    input  logic                         i_alu_odd,
    input  logic                         i_run,
    input  logic                         i_step_req,
    output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
    output logic [STEP_WIDTH-1:0]        o_step,
    output logic                         o_zero,
    output logic                         o_carry,
    output logic                         o_odd,
    output logic                         o_cycle_en,
    output logic                         o_halted,
    output logic                         o_fault,
    output logic [RETIRED_WIDTH-1:0]     o_retired
);

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    state_t state_q;
    state_t state_d;
    logic   step_req_q;
    logic   step_pulse;
    logic   last_step;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= PAUSE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and cycle enable
    always_comb begin
        state_d    = state_q;
        step_pulse = i_step_req & ~step_req_q;
        last_step  = (o_step == LAST_STEP);
        o_cycle_en = (state_q == RUN) | ((state_q == PAUSE) & step_pulse);

        case (state_q)
            PAUSE:   if (i_run)  state_d = RUN;
            RUN:     if (!i_run) state_d = PAUSE;
            default: state_d = HALT;
        endcase

        // A committed halt or a step overflow wins over run/pause tracking
        if (o_cycle_en && (i_hlt || (!i_adv && last_step))) begin
            state_d = HALT;
        end
    end

    // Datapath registers, all gated by the cycle enable
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            step_req_q    <= 1'b0;
            o_instruction <= '0;
            o_step        <= '0;
            o_zero        <= 1'b0;
            o_carry       <= 1'b0;
            o_odd         <= 1'b0;
            o_halted      <= 1'b0;
            o_fault       <= 1'b0;
            o_retired     <= '0;
        end else begin
            step_req_q <= i_step_req;
            if (o_cycle_en) begin
                if (i_ii) begin
                    o_instruction <= i_bus;
                end
                if (i_el) begin
                    o_zero  <= i_alu_zero;
                    o_carry <= i_alu_carry;
                    o_odd   <= i_alu_odd;
                end
                if (i_hlt) begin
                    o_halted <= 1'b1;
                end else if (i_adv) begin
                    o_step    <= '0;
                    o_retired <= o_retired + RETIRED_WIDTH'(1);
                end else if (last_step) begin
                    o_fault  <= 1'b1;
                    o_halted <= 1'b1;
                end else begin
                    o_step <= o_step + STEP_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer; a second instance with a 2-bit retired
// counter shares the stimulus so the counter wrap is reachable quickly.
module tb_micro_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_bus;
    logic        i_ii, i_el, i_adv, i_hlt;
    logic        i_alu_zero, i_alu_carry, i_alu_odd;
    logic        i_run, i_step_req;

    logic [15:0] o_instruction;
    logic [4:0]  o_step;
    logic        o_zero, o_carry, o_odd, o_cycle_en, o_halted, o_fault;
    logic [31:0] o_retired;

    logic [15:0] w_instruction;
    logic [4:0]  w_step;
    logic        w_zero, w_carry, w_odd, w_cycle_en, w_halted, w_fault;
    logic [1:0]  w_retired;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    micro_sequencer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_bus(i_bus),
        .i_ii(i_ii), .i_el(i_el), .i_adv(i_adv), .i_hlt(i_hlt),
        .i_alu_zero(i_alu_zero), .i_alu_carry(i_alu_carry), .i_alu_odd(i_alu_odd),
        .i_run(i_run), .i_step_req(i_step_req),
        .o_instruction(o_instruction), .o_step(o_step),
        .o_zero(o_zero), .o_carry(o_carry), .o_odd(o_odd),
        .o_cycle_en(o_cycle_en), .o_halted(o_halted), .o_fault(o_fault),
        .o_retired(o_retired)
    );

    micro_sequencer #(.RETIRED_WIDTH(2)) dut_w (
        .i_clk(i_clk), .i_reset(i_reset), .i_bus(i_bus),
        .i_ii(i_ii), .i_el(i_el), .i_adv(i_adv), .i_hlt(i_hlt),
        .i_alu_zero(i_alu_zero), .i_alu_carry(i_alu_carry), .i_alu_odd(i_alu_odd),
        .i_run(i_run), .i_step_req(i_step_req),
        .o_instruction(w_instruction), .o_step(w_step),
        .o_zero(w_zero), .o_carry(w_carry), .o_odd(w_odd),
        .o_cycle_en(w_cycle_en), .o_halted(w_halted), .o_fault(w_fault),
        .o_retired(w_retired)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs change and outputs are sampled on the falling edge
    task automatic cyc();
        @(negedge i_clk);
    endtask

    initial begin
        i_reset = 1'b1; i_bus = '0; i_ii = 0; i_el = 0; i_adv = 0; i_hlt = 0;
        i_alu_zero = 0; i_alu_carry = 0; i_alu_odd = 0; i_run = 0; i_step_req = 0;
        cyc(); cyc();
        i_reset = 1'b0;

        check("rst_instruction", 64'(o_instruction), 64'h0);
        check("rst_step", 64'(o_step), 64'd0);
        check("rst_flags", 64'({o_zero, o_carry, o_odd}), 64'd0);
        check("rst_halted", 64'(o_halted), 64'd0);
        check("rst_fault", 64'(o_fault), 64'd0);
        check("rst_retired", 64'(o_retired), 64'd0);
        #1 check("rst_cycle_en", 64'(o_cycle_en), 64'd0);

        // i_run for one cycle: one enabled cycle, one microstep
        i_run = 1;
        #1 check("run_en_before", 64'(o_cycle_en), 64'd0);
        cyc();
        check("run_step_hold", 64'(o_step), 64'd0);
        i_run = 0;
        #1 check("run_en_in_run", 64'(o_cycle_en), 64'd1);
        cyc();
        check("run_step_1", 64'(o_step), 64'd1);
        #1 check("run_en_paused", 64'(o_cycle_en), 64'd0);
        cyc();
        check("pause_step_hold", 64'(o_step), 64'd1);

        // Held step request yields one microstep
        i_step_req = 1;
        #1 check("step_en_pulse", 64'(o_cycle_en), 64'd1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1 check("step_en_held", 64'(o_cycle_en), 64'd0);
            cyc();
        end
        check("step_once", 64'(o_step), 64'd2);
        i_step_req = 0;
        cyc();
        i_step_req = 1;
        #1 check("step_en_again", 64'(o_cycle_en), 64'd1);
        cyc();
        check("step_twice", 64'(o_step), 64'd3);
        i_step_req = 0;

        // Reset mid-instruction
        i_reset = 1; cyc(); i_reset = 0;
        check("midrst_step", 64'(o_step), 64'd0);

        // Fetch, flag latch and retire
        i_run = 1;
        cyc();
        cyc();
        check("fetch_step1", 64'(o_step), 64'd1);
        i_ii = 1; i_bus = 16'h002a;
        cyc();
        check("fetch_instr", 64'(o_instruction), 64'h002a);
        check("fetch_step2", 64'(o_step), 64'd2);
        i_ii = 0; i_bus = 16'hffff;
        i_el = 1; i_alu_zero = 1; i_alu_carry = 0; i_alu_odd = 1;
        cyc();
        check("el_flags", 64'({o_zero, o_carry, o_odd}), 64'b101);
        check("el_step3", 64'(o_step), 64'd3);
        i_el = 0; i_alu_zero = 0; i_alu_carry = 1; i_alu_odd = 0;
        i_adv = 1;
        cyc();
        check("adv_step0", 64'(o_step), 64'd0);
        check("adv_retired", 64'(o_retired), 64'd1);
        check("flags_hold", 64'({o_zero, o_carry, o_odd}), 64'b101);
        check("instr_hold", 64'(o_instruction), 64'h002a);
        i_adv = 0;
        cyc(); cyc();
        check("hlt_at_step2", 64'(o_step), 64'd2);

        // HLT with ADV: halt wins, II still commits
        i_hlt = 1; i_adv = 1; i_ii = 1; i_bus = 16'h1234;
        cyc();
        check("hlt_halted", 64'(o_halted), 64'd1);
        check("hlt_step", 64'(o_step), 64'd2);
        check("hlt_retired", 64'(o_retired), 64'd1);
        check("hlt_ii_commit", 64'(o_instruction), 64'h1234);
        check("hlt_no_fault", 64'(o_fault), 64'd0);
        i_hlt = 0; i_adv = 0; i_ii = 0;
        #1 check("hlt_en_off", 64'(o_cycle_en), 64'd0);
        cyc();
        check("hlt_step_hold", 64'(o_step), 64'd2);
        i_step_req = 1;
        #1 check("hlt_step_req_ignored", 64'(o_cycle_en), 64'd0);
        i_step_req = 0; i_run = 0;
        i_reset = 1; cyc(); i_reset = 0;
        check("clr_halted", 64'(o_halted), 64'd0);
        check("clr_retired", 64'(o_retired), 64'd0);
        check("clr_instr", 64'(o_instruction), 64'h0);
        check("clr_flags", 64'({o_zero, o_carry, o_odd}), 64'd0);

        // Step overflow without ADV
        i_run = 1;
        cyc();
        repeat (31) cyc();
        check("ovf_step31", 64'(o_step), 64'd31);
        check("ovf_no_fault_yet", 64'(o_fault), 64'd0);
        cyc();
        check("ovf_fault", 64'(o_fault), 64'd1);
        check("ovf_halted", 64'(o_halted), 64'd1);
        check("ovf_step_hold", 64'(o_step), 64'd31);
        cyc();
        #1 check("ovf_en_off", 64'(o_cycle_en), 64'd0);
        check("ovf_step_hold2", 64'(o_step), 64'd31);
        i_run = 0;
        i_reset = 1; cyc(); i_reset = 0;
        check("ovf_clr_fault", 64'(o_fault), 64'd0);

        // Run together with a step pulse in PAUSE, then retire until wrap
        i_step_req = 1; i_run = 1;
        #1 check("runpulse_en", 64'(o_cycle_en), 64'd1);
        cyc();
        check("runpulse_step", 64'(o_step), 64'd1);
        i_step_req = 0;
        #1 check("runpulse_in_run", 64'(o_cycle_en), 64'd1);
        i_adv = 1;
        cyc(); cyc(); cyc();
        check("wrap_pre_main", 64'(o_retired), 64'd3);
        check("wrap_pre_small", 64'(w_retired), 64'd3);
        cyc();
        check("wrap_main", 64'(o_retired), 64'd4);
        check("wrap_small", 64'(w_retired), 64'd0);
        i_adv = 0; i_run = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
